// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bundle: imem request/ack bus plus decoder valid/ready and control inputs.
// master = the sequencer, slave = imem + decoder environment.
interface pc_fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        dec_ready;
  logic        stall;
  logic        ctl_jump;
  logic        ctl_branch;
  logic        ctl_jr;
  logic [31:0] jr_addr;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_rdata, dec_ready, stall, ctl_jump, ctl_branch, ctl_jr, jr_addr
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_rdata, dec_ready, stall, ctl_jump, ctl_branch, ctl_jr, jr_addr
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// PC owner and fetch sequencer: IDLE -> FETCH (req/ack, timeout retry) -> ISSUE (valid/ready).
// Optional macro DELAY_SLOT_EN: redirects take effect after one delay-slot instruction.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pc_fetch_sequencer_if.master   bus,
  output logic [31:0]            pc,
  output logic                   fetch_err,
  output logic                   addr_err
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RETRY, S_ISSUE} state_t;
  state_t state;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [31:0]   pc4, br_tgt, jmp_tgt, jr_tgt, redir_tgt, next_pc;
  logic          accept, redir, jr_bad, set_addr_err;

  assign cnt_nxt = cnt + 1'b1;
  assign accept  = bus.dec_ready & ~bus.stall;
  assign redir   = bus.ctl_jr | bus.ctl_jump | bus.ctl_branch;
  assign jr_bad  = bus.ctl_jr & (|bus.jr_addr[1:0]);

  // Targets are relative to the held instruction, not the live pc register.
  assign pc4     = bus.inst_pc + 32'd4;
  assign br_tgt  = pc4 + {{14{bus.inst[15]}}, bus.inst[15:0], 2'b00};
  assign jmp_tgt = {pc4[31:28], bus.inst[25:0], 2'b00};
  assign jr_tgt  = {bus.jr_addr[31:2], 2'b00};

  always_comb begin
    redir_tgt = pc4;
    if (bus.ctl_jr)          redir_tgt = jr_tgt;
    else if (bus.ctl_jump)   redir_tgt = jmp_tgt;
    else if (bus.ctl_branch) redir_tgt = br_tgt;
  end

`ifdef DELAY_SLOT_EN
  logic [31:0] pending_target;
  logic        slot_pending;

  // The delay-slot instruction's own control inputs are ignored.
  assign next_pc      = slot_pending ? pending_target : pc4;
  assign set_addr_err = ~slot_pending & jr_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_target <= '0;
      slot_pending   <= 1'b0;
    end else if (state == S_ISSUE && accept) begin
      if (slot_pending) begin
        slot_pending <= 1'b0;
      end else if (redir) begin
        pending_target <= redir_tgt;
        slot_pending   <= 1'b1;
      end
    end
  end
`else
  assign next_pc      = redir ? redir_tgt : pc4;
  assign set_addr_err = jr_bad;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pc             <= RESET_PC;
      bus.imem_req   <= 1'b0;
      bus.imem_addr  <= RESET_PC;
      bus.inst_valid <= 1'b0;
      bus.inst       <= '0;
      bus.inst_pc    <= '0;
      fetch_err      <= 1'b0;
      addr_err       <= 1'b0;
      cnt            <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state         <= S_FETCH;
          bus.imem_req  <= 1'b1;
          bus.imem_addr <= pc;
        end
        S_FETCH: begin
          if (bus.imem_ack) begin
            bus.inst       <= bus.imem_rdata;
            bus.inst_pc    <= pc;
            bus.inst_valid <= 1'b1;
            bus.imem_req   <= 1'b0;
            cnt            <= '0;
            state          <= S_ISSUE;
          end else if (cnt_nxt == CW'(TIMEOUT)) begin
            fetch_err    <= 1'b1;
            bus.imem_req <= 1'b0;
            cnt          <= '0;
            state        <= S_RETRY;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        S_RETRY: begin
          // One-cycle request gap; any ack seen here is stale and dropped.
          state         <= S_FETCH;
          bus.imem_req  <= 1'b1;
          bus.imem_addr <= pc;
        end
        S_ISSUE: begin
          if (accept) begin
            pc             <= next_pc;
            bus.inst_valid <= 1'b0;
            bus.imem_req   <= 1'b1;
            bus.imem_addr  <= next_pc;
            state          <= S_FETCH;
            if (set_addr_err) addr_err <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
